// File: rtl/multicycle_controller_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_controller_pkg
// Definitions shared by the multicycle RV32I control FSM and its datapath
// neighbours (alu_decoder uses the same ALU_op codes):
//   - state encodings (also exported on the debug state port)
//   - major opcode constants for the supported instructions
//   - ALU_op codes and datapath mux-select codes
// ---------------------------------------------------------------------------
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_JAL       = 4'd9,
    S_BEQ       = 4'd10,
    S_TRAP      = 4'd15
  } state_t;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU_op codes understood by alu_decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Memory address select
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // lw and sw share the address-generation path; bit 5 tells them apart.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_controller_wait_counter.sv
// ---------------------------------------------------------------------------
// multicycle_controller_wait_counter
// Saturating 4-bit stall counter used to stretch memory-access states.
//   clock   : system clock
//   reset_n : asynchronous active-low reset, counter -> 0
//   clear   : synchronous clear (has priority over enable)
//   enable  : count up by one while below limit
//   limit   : saturation value; the counter never passes or wraps it
//   done    : high while the count equals limit
// ---------------------------------------------------------------------------
module multicycle_controller_wait_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] limit,
  output logic       done
);

  logic [3:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= 4'd0;
    end else if (clear) begin
      count_reg <= 4'd0;
    end else if (enable && (count_reg < limit)) begin
      count_reg <= count_reg + 4'd1;
    end
  end

  assign done = (count_reg == limit);

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Main control FSM of the multicycle RV32I core. Steps each instruction
// through fetch / decode / execute / memory / writeback and drives the
// datapath selects and write enables. Supports lw, sw, R-type, I-type ALU,
// jal and beq; anything else enters a sticky TRAP state.
//   clock      : system clock
//   reset_n    : asynchronous active-low reset
//   opcode     : instr[6:0] from the instruction register
//   ALU_op     : to alu_decoder (00 add, 01 sub, 10 funct-decoded)
//   ALU_src_A  : 00 PC, 01 old PC, 10 rs1
//   ALU_src_B  : 00 rs2, 01 immediate, 10 constant 4
//   result_src : 00 ALU-out reg, 01 data reg, 10 live ALU result
//   adr_src    : memory address, 0 PC, 1 result
//   IR_write   : load IR and old-PC registers
//   PC_update  : unconditional PC write
//   branch     : PC write qualified by ALU zero
//   reg_write  : register-file write
//   mem_write  : data-memory write
//   illegal    : high while trapped
//   state      : current state encoding (debug)
// Parameter MEM_WAIT (0-15): extra stall cycles in FETCH and MEM_READ.
// ---------------------------------------------------------------------------
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  output logic [1:0] ALU_op,
  output logic [1:0] ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       IR_write,
  output logic       PC_update,
  output logic       branch,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_reg;
  state_t state_next;

  logic wait_clear;
  logic wait_enable;
  logic wait_done;

  // Raw enables decoded from state; gated with reset_n before leaving.
  logic ir_write_raw;
  logic pc_update_raw;
  logic branch_raw;
  logic reg_write_raw;
  logic mem_write_raw;

  // -------------------------------------------------------------------------
  // Stall counter: counts only in the memory-access states and restarts on
  // every state change, so each FETCH/MEM_READ visit waits MEM_WAIT cycles.
  // -------------------------------------------------------------------------
  assign wait_enable = (state_reg == S_FETCH) || (state_reg == S_MEM_READ);
  assign wait_clear  = (state_next != state_reg);

  multicycle_controller_wait_counter u_wait (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .limit   (4'(MEM_WAIT)),
    .done    (wait_done)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. opcode is only looked at in DECODE and MEM_ADR.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (wait_done) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_mem_op(opcode))    state_next = S_MEM_ADR;
        else if (opcode == OP_R)   state_next = S_EXEC_R;
        else if (opcode == OP_I)   state_next = S_EXEC_I;
        else if (opcode == OP_JAL) state_next = S_JAL;
        else if (opcode == OP_BEQ) state_next = S_BEQ;
        else                       state_next = S_TRAP;
      end
      S_MEM_ADR: begin
        state_next = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        if (wait_done) state_next = S_MEM_WB;
      end
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = S_FETCH;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_JAL:       state_next = S_ALU_WB;
      S_BEQ:       state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      // Unused encodings are treated as a fault and trap.
      default:     state_next = S_TRAP;
    endcase
  end

  // -------------------------------------------------------------------------
  // Moore output decode
  // -------------------------------------------------------------------------
  always_comb begin
    ALU_op        = ALU_OP_ADD;
    ALU_src_A     = SRC_A_PC;
    ALU_src_B     = SRC_B_RS2;
    result_src    = RES_ALU_OUT;
    adr_src       = ADR_PC;
    ir_write_raw  = 1'b0;
    pc_update_raw = 1'b0;
    branch_raw    = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ALU_src_A  = SRC_A_PC;
        ALU_src_B  = SRC_B_FOUR;
        ALU_op     = ALU_OP_ADD;
        result_src = RES_ALU;
        adr_src    = ADR_PC;
        // Latch the instruction and advance PC only once memory data is valid.
        ir_write_raw  = wait_done;
        pc_update_raw = wait_done;
      end
      S_DECODE: begin
        // Precompute the branch target: old PC + immediate.
        ALU_src_A = SRC_A_OLD_PC;
        ALU_src_B = SRC_B_IMM;
        ALU_op    = ALU_OP_ADD;
      end
      S_MEM_ADR: begin
        ALU_src_A = SRC_A_RS1;
        ALU_src_B = SRC_B_IMM;
        ALU_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        adr_src    = ADR_RESULT;
        result_src = RES_ALU_OUT;
      end
      S_MEM_WB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src       = ADR_RESULT;
        result_src    = RES_ALU_OUT;
        mem_write_raw = 1'b1;
      end
      S_EXEC_R: begin
        ALU_src_A = SRC_A_RS1;
        ALU_src_B = SRC_B_RS2;
        ALU_op    = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        ALU_src_A = SRC_A_RS1;
        ALU_src_B = SRC_B_IMM;
        ALU_op    = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        result_src    = RES_ALU_OUT;
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        // PC <- branch target from DECODE; ALU forms old PC + 4 for rd.
        ALU_src_A     = SRC_A_OLD_PC;
        ALU_src_B     = SRC_B_FOUR;
        ALU_op        = ALU_OP_ADD;
        result_src    = RES_ALU_OUT;
        pc_update_raw = 1'b1;
      end
      S_BEQ: begin
        ALU_src_A  = SRC_A_RS1;
        ALU_src_B  = SRC_B_RS2;
        ALU_op     = ALU_OP_SUB;
        result_src = RES_ALU_OUT;
        branch_raw = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // Reset drops every write enable immediately, without waiting for a clock;
  // in reset the state is FETCH, which would otherwise request IR_write.
  assign IR_write  = ir_write_raw  & reset_n;
  assign PC_update = pc_update_raw & reset_n;
  assign branch    = branch_raw    & reset_n;
  assign reg_write = reg_write_raw & reset_n;
  assign mem_write = mem_write_raw & reset_n;

  assign state = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for the multicycle control FSM. Two instances share clock,
// reset and opcode: d0 with MEM_WAIT=0 and d2 with MEM_WAIT=2.
// Enable vector order: {IR_write, PC_update, branch, reg_write, mem_write}.
// Select vector order: {ALU_op, ALU_src_A, ALU_src_B, result_src, adr_src}.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;

  logic [1:0] d0_alu_op, d0_src_a, d0_src_b, d0_res;
  logic       d0_adr, d0_ir, d0_pcu, d0_br, d0_rw, d0_mw, d0_ill;
  logic [3:0] d0_state;
  logic [1:0] d2_alu_op, d2_src_a, d2_src_b, d2_res;
  logic       d2_adr, d2_ir, d2_pcu, d2_br, d2_rw, d2_mw, d2_ill;
  logic [3:0] d2_state;

  wire [4:0] d0_en  = {d0_ir, d0_pcu, d0_br, d0_rw, d0_mw};
  wire [4:0] d2_en  = {d2_ir, d2_pcu, d2_br, d2_rw, d2_mw};
  wire [8:0] d0_sel = {d0_alu_op, d0_src_a, d0_src_b, d0_res, d0_adr};
  wire [8:0] d2_sel = {d2_alu_op, d2_src_a, d2_src_b, d2_res, d2_adr};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT(0)) d0 (
    .clock(clk), .reset_n(reset_n), .opcode(opcode),
    .ALU_op(d0_alu_op), .ALU_src_A(d0_src_a), .ALU_src_B(d0_src_b),
    .result_src(d0_res), .adr_src(d0_adr), .IR_write(d0_ir),
    .PC_update(d0_pcu), .branch(d0_br), .reg_write(d0_rw),
    .mem_write(d0_mw), .illegal(d0_ill), .state(d0_state)
  );

  multicycle_controller #(.MEM_WAIT(2)) d2 (
    .clock(clk), .reset_n(reset_n), .opcode(opcode),
    .ALU_op(d2_alu_op), .ALU_src_A(d2_src_a), .ALU_src_B(d2_src_b),
    .result_src(d2_res), .adr_src(d2_adr), .IR_write(d2_ir),
    .PC_update(d2_pcu), .branch(d2_br), .reg_write(d2_rw),
    .mem_write(d2_mw), .illegal(d2_ill), .state(d2_state)
  );

  // Advance one cycle; sample point is 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Hold reset two cycles, release on a falling edge (state 0 = cycle 0).
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (d0_state !== 4'd0 || d2_state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got d0=%0d d2=%0d expected 0", d0_state, d2_state);
    end
    checks++;
    if (d0_en !== 5'b00000 || d2_en !== 5'b00000) begin
      errors++;
      $display("FAIL reset_enables got d0=%b d2=%b expected 00000", d0_en, d2_en);
    end
    checks++;
    if (d0_sel !== 9'b00_00_10_10_0) begin
      errors++;
      $display("FAIL reset_selects got %b expected 000010100", d0_sel);
    end
    checks++;
    if (d0_ill !== 1'b0 || d2_ill !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal got d0=%b d2=%b expected 0", d0_ill, d2_ill);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [0:4];
    logic [4:0] exp_en [0:4];
    logic [8:0] exp_sel [0:4];
    exp_st  = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    exp_en  = '{5'b11000, 5'b00000, 5'b00000, 5'b00010, 5'b11000};
    exp_sel = '{9'b00_00_10_10_0, 9'b00_01_01_00_0, 9'b10_10_00_00_0,
                9'b00_00_00_00_0, 9'b00_00_10_10_0};
    opcode = 7'b0110011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (d0_state !== exp_st[i]) begin
        errors++;
        $display("FAIL rtype_state cyc=%0d got=%0d expected=%0d", i, d0_state, exp_st[i]);
      end
      checks++;
      if (d0_en !== exp_en[i]) begin
        errors++;
        $display("FAIL rtype_en cyc=%0d got=%b expected=%b", i, d0_en, exp_en[i]);
      end
      checks++;
      if (d0_sel !== exp_sel[i]) begin
        errors++;
        $display("FAIL rtype_sel cyc=%0d got=%b expected=%b", i, d0_sel, exp_sel[i]);
      end
      // After DECODE has committed, a garbage opcode must not matter.
      if (i == 2) opcode = 7'b0000000;
      tick();
    end
  endtask

  task automatic test_itype();
    logic [3:0] exp_st [0:4];
    logic [8:0] exp_sel [0:4];
    exp_st  = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    exp_sel = '{9'b00_00_10_10_0, 9'b00_01_01_00_0, 9'b10_10_01_00_0,
                9'b00_00_00_00_0, 9'b00_00_10_10_0};
    opcode = 7'b0010011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (d0_state !== exp_st[i] || d0_sel !== exp_sel[i]) begin
        errors++;
        $display("FAIL itype cyc=%0d got state=%0d sel=%b expected state=%0d sel=%b",
                 i, d0_state, d0_sel, exp_st[i], exp_sel[i]);
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_st2 [0:9];
    logic [4:0] exp_en2 [0:9];
    logic [8:0] exp_sel2 [0:9];
    logic [3:0] exp_st0 [0:9];
    exp_st2  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    exp_en2  = '{5'b00000, 5'b00000, 5'b11000, 5'b00000, 5'b00000,
                 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000};
    exp_sel2 = '{9'b00_00_10_10_0, 9'b00_00_10_10_0, 9'b00_00_10_10_0,
                 9'b00_01_01_00_0, 9'b00_10_01_00_0, 9'b00_00_00_00_1,
                 9'b00_00_00_00_1, 9'b00_00_00_00_1, 9'b00_00_00_01_0,
                 9'b00_00_10_10_0};
    exp_st0  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    opcode = 7'b0000011;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (d2_state !== exp_st2[i]) begin
        errors++;
        $display("FAIL lw2_state cyc=%0d got=%0d expected=%0d", i, d2_state, exp_st2[i]);
      end
      checks++;
      if (d2_en !== exp_en2[i]) begin
        errors++;
        $display("FAIL lw2_en cyc=%0d got=%b expected=%b", i, d2_en, exp_en2[i]);
      end
      checks++;
      if (d2_sel !== exp_sel2[i]) begin
        errors++;
        $display("FAIL lw2_sel cyc=%0d got=%b expected=%b", i, d2_sel, exp_sel2[i]);
      end
      checks++;
      if (d0_state !== exp_st0[i]) begin
        errors++;
        $display("FAIL lw0_state cyc=%0d got=%0d expected=%0d", i, d0_state, exp_st0[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [0:4];
    logic [4:0] exp_en [0:4];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    exp_en = '{5'b11000, 5'b00000, 5'b00000, 5'b00001, 5'b11000};
    opcode = 7'b0100011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (d0_state !== exp_st[i] || d0_en !== exp_en[i]) begin
        errors++;
        $display("FAIL sw cyc=%0d got state=%0d en=%b expected state=%0d en=%b",
                 i, d0_state, d0_en, exp_st[i], exp_en[i]);
      end
      if (i == 3) begin
        checks++;
        if (d0_sel !== 9'b00_00_00_00_1) begin
          errors++;
          $display("FAIL sw_sel got=%b expected=000000001", d0_sel);
        end
      end
      tick();
    end
  endtask

  task automatic test_beq();
    logic [3:0] exp_st [0:3];
    logic [4:0] exp_en [0:3];
    exp_st = '{4'd0, 4'd1, 4'd10, 4'd0};
    exp_en = '{5'b11000, 5'b00000, 5'b00100, 5'b11000};
    opcode = 7'b1100011;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (d0_state !== exp_st[i] || d0_en !== exp_en[i]) begin
        errors++;
        $display("FAIL beq cyc=%0d got state=%0d en=%b expected state=%0d en=%b",
                 i, d0_state, d0_en, exp_st[i], exp_en[i]);
      end
      if (i == 2) begin
        checks++;
        if (d0_sel !== 9'b01_10_00_00_0) begin
          errors++;
          $display("FAIL beq_sel got=%b expected=011000000", d0_sel);
        end
      end
      tick();
    end
  endtask

  task automatic test_jal();
    logic [3:0] exp_st [0:4];
    logic [4:0] exp_en [0:4];
    exp_st = '{4'd0, 4'd1, 4'd9, 4'd8, 4'd0};
    exp_en = '{5'b11000, 5'b00000, 5'b01000, 5'b00010, 5'b11000};
    opcode = 7'b1101111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (d0_state !== exp_st[i] || d0_en !== exp_en[i]) begin
        errors++;
        $display("FAIL jal cyc=%0d got state=%0d en=%b expected state=%0d en=%b",
                 i, d0_state, d0_en, exp_st[i], exp_en[i]);
      end
      if (i == 2) begin
        checks++;
        if (d0_sel !== 9'b00_01_10_00_0) begin
          errors++;
          $display("FAIL jal_sel got=%b expected=000110000", d0_sel);
        end
      end
      tick();
    end
  endtask

  task automatic test_trap();
    int bad;
    opcode = 7'b0000000;
    do_reset();
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 22; i++) begin
      if (d0_state !== 4'd15 || d0_ill !== 1'b1 || d0_en !== 5'b00000) bad++;
      // Opcode wiggles must not free the trap.
      opcode = 7'b0110011;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL trap_sticky bad_cycles=%0d expected 0 (last state=%0d illegal=%b en=%b)",
               bad, d0_state, d0_ill, d0_en);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (d0_state !== 4'd0 || d0_ill !== 1'b0) begin
      errors++;
      $display("FAIL trap_exit got state=%0d illegal=%b expected state=0 illegal=0",
               d0_state, d0_ill);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (d0_state !== 4'd0 || d0_en !== 5'b11000) begin
      errors++;
      $display("FAIL trap_release got state=%0d en=%b expected state=0 en=11000",
               d0_state, d0_en);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp_en [0:2];
    // d0: reset in the middle of MEM_WB while reg_write is high.
    opcode = 7'b0000011;
    do_reset();
    repeat (4) tick();
    checks++;
    if (d0_state !== 4'd4 || d0_rw !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got state=%0d reg_write=%b expected state=4 reg_write=1",
               d0_state, d0_rw);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (d0_rw !== 1'b0 || d0_en !== 5'b00000 || d0_state !== 4'd0) begin
      errors++;
      $display("FAIL arst_drop got state=%0d en=%b expected state=0 en=00000",
               d0_state, d0_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (d0_state !== 4'd0 || d0_en !== 5'b11000) begin
      errors++;
      $display("FAIL arst_release got state=%0d en=%b expected state=0 en=11000",
               d0_state, d0_en);
    end
    // d2: reset mid MEM_READ with a non-zero count; FETCH must restart at 0.
    repeat (6) tick();
    checks++;
    if (d2_state !== 4'd3) begin
      errors++;
      $display("FAIL arst2_pre got state=%0d expected 3", d2_state);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (d2_state !== 4'd0 || d2_en !== 5'b00000) begin
      errors++;
      $display("FAIL arst2_drop got state=%0d en=%b expected state=0 en=00000",
               d2_state, d2_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    exp_en = '{5'b00000, 5'b00000, 5'b11000};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d2_state !== 4'd0 || d2_en !== exp_en[i]) begin
        errors++;
        $display("FAIL arst2_fetch cyc=%0d got state=%0d en=%b expected state=0 en=%b",
                 i, d2_state, d2_en, exp_en[i]);
      end
      tick();
    end
    checks++;
    if (d2_state !== 4'd1) begin
      errors++;
      $display("FAIL arst2_decode got state=%0d expected 1", d2_state);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_sw();
    test_beq();
    test_jal();
    test_trap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback phases, and drives the datapath mux selects and write enables. Its ALU_op output feeds alu_decoder directly; alu_decoder combines ALU_op with funct3/funct7b5 to produce ALU_control. Supported instructions: lw, sw, R-type, I-type ALU, jal, beq. Any other opcode traps.

Parameters:
MEM_WAIT, 0, extra stall cycles spent in FETCH and in MEM_READ before the memory data is taken (range 0-15).

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
opcode  input  7  instr[6:0] from the instruction register
ALU_op  output  2  to alu_decoder: 00 add, 01 subtract, 10 funct-decoded
ALU_src_A  output  2  00 PC, 01 old PC, 10 rs1 data
ALU_src_B  output  2  00 rs2 data, 01 immediate, 10 constant 4
result_src  output  2  00 ALU-out register, 01 data register, 10 live ALU result
adr_src  output  1  memory address select: 0 PC, 1 result
IR_write  output  1  load the instruction register and old-PC register
PC_update  output  1  unconditional PC write
branch  output  1  PC write qualified by ALU zero (the datapath does the AND/OR)
reg_write  output  1  register-file write
mem_write  output  1  data-memory write
illegal  output  1  high while in TRAP
state  output  4  current state encoding, for debug and the bench

Behaviour:
- Moore FSM with registered state. Outputs decode combinationally from state plus the wait counter.
- Async reset: state=FETCH, wait counter=0. While reset_n=0, force IR_write, PC_update, branch, reg_write and mem_write to 0. Selects take their FETCH values. illegal=0.
- State encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, JAL 9, BEQ 10, TRAP 15.
- Any output not listed for a state is 0.
- FETCH: adr_src=0, ALU_src_A=00, ALU_src_B=10, ALU_op=00, result_src=10. IR_write=1 and PC_update=1 on the final fetch cycle only (counter==MEM_WAIT). Then go to DECODE.
- DECODE: A=01, B=01, ALU_op=00 (precompute the branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> TRAP
- MEM_ADR: A=10, B=01, ALU_op=00. Next is MEM_READ if opcode[5]=0, MEM_WRITE if opcode[5]=1.
- MEM_READ: adr_src=1, result_src=00. Holds until counter==MEM_WAIT, then goes to MEM_WB.
- MEM_WB: result_src=01, reg_write=1 -> FETCH.
- MEM_WRITE: adr_src=1, result_src=00, mem_write=1 for exactly one cycle -> FETCH.
- EXEC_R: A=10, B=00, ALU_op=10 -> ALU_WB.
- EXEC_I: A=10, B=01, ALU_op=10 -> ALU_WB.
- ALU_WB: result_src=00, reg_write=1 -> FETCH.
- JAL: A=01, B=10, ALU_op=00, result_src=00, PC_update=1 -> ALU_WB (writes rd=PC+4).
- BEQ: A=10, B=00, ALU_op=01, result_src=00, branch=1 -> FETCH.
- TRAP: all enables 0, illegal=1. Sticky; only reset_n leaves it.
- Wait counter (4 bits):
  - Increments each cycle in FETCH or MEM_READ while below MEM_WAIT.
  - Clears to 0 on every state change.
  - Saturates at MEM_WAIT and never wraps.
  - With MEM_WAIT=0, FETCH and MEM_READ last exactly one cycle.
- Instruction latency in cycles, with MEM_WAIT=0: lw 5; sw 4; R/I 4; jal 4; beq 3. Each FETCH/MEM_READ visit adds MEM_WAIT cycles.
- opcode is sampled only in DECODE and MEM_ADR; changes in other states are ignored.
- Reset asserted mid-instruction: immediate return to FETCH, and any in-flight write enable drops in the same cycle, asynchronously.

Decomposition:
- Shared header cpu_defines.vh holds:
  - state encodings
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ALU_op codes 00/01/10, shared with alu_decoder
  - src-select codes
- One sub-module, wait_counter: clock, reset_n, clear, enable, limit -> done. It implements the saturating 4-bit counter.

Test Plan:
- Reset, then release with opcode=0110011 and MEM_WAIT=0 -> state sequence 0,1,6,8,0. ALU_op=10 in EXEC_R. reg_write=1 only in the ALU_WB cycle. IR_write=PC_update=1 in cycle 0 only.
- lw (0000011) with MEM_WAIT=2 -> FETCH lasts 3 cycles, IR_write only on the 3rd. Then 1,2; MEM_READ lasts 3 cycles with adr_src=1; then MEM_WB with result_src=01 and reg_write=1. Total 9 cycles.
- sw (0100011) -> 0,1,2,5,0. mem_write=1 for exactly one cycle. reg_write never asserts.
- beq (1100011) -> 0,1,10,0 with ALU_op=01 and branch=1 in BEQ. jal (1101111) -> 0,1,9,8,0 with PC_update=1 in JAL.
- Opcode 0000000 in DECODE -> state=15, illegal=1, all enables 0 for 20+ cycles. Pulse reset_n low -> state=0, illegal=0.
- Assert reset_n low asynchronously mid-MEM_WB (reg_write=1) -> reg_write drops before the next clock edge. After release, state=0 and the counter is 0.
